// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that time-shares one 8-bit signed shift-add
// multiplier between NREQ requesters (load B, run with A, capture, rest).
module mult_arbiter #(
   parameter int NREQ        = 2,
   parameter int RUN_CYCLES  = 20,
   parameter int REST_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [15:0]       product,
   output logic              busy,
   output logic [7:0]        mult_S,
   output logic              mult_ClearA_LoadB,
   output logic              mult_Run,
   input  logic [7:0]        mult_Aval,
   input  logic [7:0]        mult_Bval
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(RUN_CYCLES + REST_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_RUN     = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;

   localparam logic [CW-1:0] C_ZERO      = {CW{1'b0}};
   localparam logic [CW-1:0] C_ONE       = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_RUN_LOAD  = CW'(RUN_CYCLES - 1);
   localparam logic [CW-1:0] C_REST_LOAD = CW'(REST_CYCLES - 1);

   logic [2:0]      r_state;
   logic [IW-1:0]   r_gnt;
   logic [IW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_cnt;

   logic            w_any_req;
   logic [IW-1:0]   w_pick;
   logic [IW-1:0]   w_next_ptr;
   logic [7:0]      w_pick_b;
   logic [7:0]      w_op_a;
   logic [NREQ-1:0] w_gnt_onehot;

   // First pending requester at or above ptr, wrapping; the descending scan lets
   // the smallest offset from ptr win.
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IW-1:0]   ptr);
      logic [IW-1:0] idx;
      logic [IW-1:0] sel;
      sel = ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % NREQ);
         if (v[idx]) begin
            sel = idx;
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction

   // Arbitration pick and operand muxes; operands are read live, never copied.
   always_comb begin
      w_any_req    = |req_valid;
      w_pick       = rr_pick(req_valid, r_rr_ptr);
      w_next_ptr   = IW'((int'(r_gnt) + 1) % NREQ);
      w_pick_b     = 8'h00;
      w_op_a       = 8'h00;
      w_gnt_onehot = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         w_pick_b        = w_pick_b | (req_b[i*8 +: 8] & {8{w_pick == IW'(i)}});
         w_op_a          = w_op_a   | (req_a[i*8 +: 8] & {8{r_gnt  == IW'(i)}});
         w_gnt_onehot[i] = (r_gnt == IW'(i));
      end
   end

   // Sequencer; every output is a register loaded with the value for the next state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state           <= S_IDLE;
         r_gnt             <= {IW{1'b0}};
         r_rr_ptr          <= {IW{1'b0}};
         r_cnt             <= C_ZERO;
         rsp_valid         <= {NREQ{1'b0}};
         product           <= 16'h0000;
         busy              <= 1'b0;
         mult_S            <= 8'h00;
         mult_ClearA_LoadB <= 1'b0;
         mult_Run          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               rsp_valid <= {NREQ{1'b0}};
               mult_Run  <= 1'b0;
               if (w_any_req) begin
                  r_gnt             <= w_pick;
                  mult_S            <= w_pick_b;
                  mult_ClearA_LoadB <= 1'b1;
                  busy              <= 1'b1;
                  r_state           <= S_LOAD;
               end else begin
                  mult_S            <= 8'h00;
                  mult_ClearA_LoadB <= 1'b0;
                  busy              <= 1'b0;
                  r_state           <= S_IDLE;
               end
            end
            S_LOAD: begin
               mult_S            <= w_op_a;
               mult_ClearA_LoadB <= 1'b0;
               r_state           <= S_SETTLE;
            end
            S_SETTLE: begin
               mult_S   <= w_op_a;
               mult_Run <= 1'b1;
               r_cnt    <= C_RUN_LOAD;
               r_state  <= S_RUN;
            end
            S_RUN: begin
               mult_S <= w_op_a;
               if (r_cnt == C_ZERO) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end
            S_CAPTURE: begin
               product   <= {mult_Aval, mult_Bval};
               rsp_valid <= w_gnt_onehot;
               r_rr_ptr  <= w_next_ptr;
               mult_Run  <= 1'b0;
               mult_S    <= 8'h00;
               r_cnt     <= C_REST_LOAD;
               r_state   <= S_RELEASE;
            end
            S_RELEASE: begin
               rsp_valid <= {NREQ{1'b0}};
               if (r_cnt == C_ZERO) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end
            default: begin
               r_state           <= S_IDLE;
               rsp_valid         <= {NREQ{1'b0}};
               busy              <= 1'b0;
               mult_S            <= 8'h00;
               mult_ClearA_LoadB <= 1'b0;
               mult_Run          <= 1'b0;
            end
         endcase
      end
   end

   mult_arbiter_checker #(.NREQ(NREQ)) u_checker (
      .Clk               (Clk),
      .Reset             (Reset),
      .rsp_valid         (rsp_valid),
      .mult_S            (mult_S),
      .mult_ClearA_LoadB (mult_ClearA_LoadB),
      .mult_Run          (mult_Run)
   );
endmodule

// Protocol properties of the multiplier-side and response interfaces.
module mult_arbiter_checker #(
   parameter int NREQ = 2
) (
   input logic            Clk,
   input logic            Reset,
   input logic [NREQ-1:0] rsp_valid,
   input logic [7:0]      mult_S,
   input logic            mult_ClearA_LoadB,
   input logic            mult_Run
);
   a_load_run_excl: assert property (@(posedge Clk) disable iff (Reset)
      !(mult_ClearA_LoadB && mult_Run));

   a_rsp_onehot: assert property (@(posedge Clk) disable iff (Reset)
      $onehot0(rsp_valid));

   a_rsp_pulse: assert property (@(posedge Clk) disable iff (Reset)
      (|rsp_valid) |=> (rsp_valid == {NREQ{1'b0}}));

   a_s_stable_run: assert property (@(posedge Clk) disable iff (Reset)
      mult_Run |=> (!mult_Run || $stable(mult_S)));
endmodule
